// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter sharing one blocking cache request port among NUM_REQ requesters.
// One transaction in flight: IDLE -> ISSUE -> (WAIT_RSP -> DELIVER) -> IDLE.
module cache_port_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int W       = 64,
  parameter int TIMEOUT = 1024
) (
  input  logic                 clk_in,
  input  logic                 rst_N_in,
  input  logic [NUM_REQ-1:0]   hc_valid_in,
  output logic [NUM_REQ-1:0]   hc_ready_out,
  input  logic [NUM_REQ*W-1:0] hc_addr_in,
  input  logic [NUM_REQ*W-1:0] hc_value_in,
  input  logic [NUM_REQ-1:0]   hc_we_in,
  output logic [NUM_REQ-1:0]   hc_valid_out,
  input  logic [NUM_REQ-1:0]   hc_ready_in,
  output logic [W-1:0]         hc_value_out,
  output logic [W-1:0]         hc_addr_out,
  output logic                 lc_valid_out,
  input  logic                 lc_ready_in,
  output logic [W-1:0]         lc_addr_out,
  output logic [W-1:0]         lc_value_out,
  output logic                 lc_we_out,
  input  logic                 lc_valid_in,
  output logic                 lc_ready_out,
  input  logic [W-1:0]         lc_value_in,
  output logic                 busy_out,
  output logic                 timeout_out
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, DELIVER} state_t;

  typedef struct packed {
    logic [W-1:0]  addr;
    logic [W-1:0]  value;
    logic          we;
    logic [PW-1:0] id;
  } req_t;

  state_t                    state_q, state_d;
  req_t                      req_q;
  logic [W-1:0]              rsp_q;
  logic [CW-1:0]             cnt_q;
  logic [PW-1:0]             rr_ptr, gnt_idx;
  logic                      gnt_vld, timeout_q;
  logic [NUM_REQ-1:0][W-1:0] addr_v, value_v;

  assign addr_v  = hc_addr_in;
  assign value_v = hc_value_in;

  function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return PW'(s);
  endfunction

  // Scan from the far end so the requester closest to rr_ptr wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      if (hc_valid_in[rr_idx(rr_ptr, k)]) begin
        gnt_vld = 1'b1;
        gnt_idx = rr_idx(rr_ptr, k);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (gnt_vld) state_d = ISSUE;
      ISSUE:    if (lc_ready_in) state_d = req_q.we ? IDLE : WAIT_RSP;
      WAIT_RSP: begin
        if (lc_valid_in)                     state_d = DELIVER;
        else if (cnt_q == CW'(TIMEOUT - 1))  state_d = IDLE;
      end
      DELIVER:  if (hc_ready_in[req_q.id]) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      req_q     <= '0;
      rsp_q     <= '0;
      cnt_q     <= '0;
      rr_ptr    <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: if (gnt_vld) begin
          req_q.addr  <= addr_v[gnt_idx];
          req_q.value <= value_v[gnt_idx];
          req_q.we    <= hc_we_in[gnt_idx];
          req_q.id    <= gnt_idx;
          rr_ptr      <= rr_idx(gnt_idx, 1);
        end
        ISSUE: cnt_q <= '0;
        WAIT_RSP: begin
          if (lc_valid_in) begin
            rsp_q <= lc_value_in;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CW'(TIMEOUT - 1)) timeout_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    lc_valid_out = (state_q == ISSUE);
    lc_ready_out = (state_q == WAIT_RSP);
    busy_out     = (state_q != IDLE);
    hc_value_out = '0;
    hc_addr_out  = '0;
    if (state_q == DELIVER) begin
      hc_value_out = rsp_q;
      hc_addr_out  = req_q.addr;
    end
  end

  assign lc_addr_out  = req_q.addr;
  assign lc_value_out = req_q.value;
  assign lc_we_out    = req_q.we;
  assign timeout_out  = timeout_q;

  // Ready is gated by reset so every output reads zero while reset is held.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign hc_ready_out[i] = rst_N_in && (state_q == IDLE) && gnt_vld && (gnt_idx == PW'(i));
    assign hc_valid_out[i] = (state_q == DELIVER) && (req_q.id == PW'(i));
  end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Bench for cache_port_arbiter: directed scenarios plus a randomized run against a
// transaction-level model of the arbiter and a reactive cache/requester environment.
module tb_cache_port_arbiter;
  localparam int N  = 2;
  localparam int W  = 64;
  localparam int TO = 16;

  logic           clk_in = 1'b0;
  logic           rst_N_in;
  logic [N-1:0]   hc_valid_in, hc_ready_out, hc_we_in, hc_valid_out, hc_ready_in;
  logic [N*W-1:0] hc_addr_in, hc_value_in;
  logic [W-1:0]   hc_value_out, hc_addr_out, lc_addr_out, lc_value_out, lc_value_in;
  logic           lc_valid_out, lc_ready_in, lc_we_out, lc_valid_in, lc_ready_out;
  logic           busy_out, timeout_out;
  int             n_pass, n_total;

  cache_port_arbiter #(.NUM_REQ(N), .W(W), .TIMEOUT(TO)) dut (
    .clk_in(clk_in), .rst_N_in(rst_N_in),
    .hc_valid_in(hc_valid_in), .hc_ready_out(hc_ready_out),
    .hc_addr_in(hc_addr_in), .hc_value_in(hc_value_in), .hc_we_in(hc_we_in),
    .hc_valid_out(hc_valid_out), .hc_ready_in(hc_ready_in),
    .hc_value_out(hc_value_out), .hc_addr_out(hc_addr_out),
    .lc_valid_out(lc_valid_out), .lc_ready_in(lc_ready_in),
    .lc_addr_out(lc_addr_out), .lc_value_out(lc_value_out), .lc_we_out(lc_we_out),
    .lc_valid_in(lc_valid_in), .lc_ready_out(lc_ready_out), .lc_value_in(lc_value_in),
    .busy_out(busy_out), .timeout_out(timeout_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic clear_inputs;
    hc_valid_in = '0; hc_we_in = '0; hc_ready_in = '0;
    hc_addr_in  = '0; hc_value_in = '0;
    lc_ready_in = 1'b0; lc_valid_in = 1'b0; lc_value_in = '0;
  endtask

  task automatic apply_reset;
    clear_inputs();
    rst_N_in = 1'b0;
    repeat (2) tick();
    rst_N_in = 1'b1;
    tick();
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] d, input logic we);
    hc_valid_in[i]       = 1'b1;
    hc_addr_in[i*W +: W]  = a;
    hc_value_in[i*W +: W] = d;
    hc_we_in[i]          = we;
  endtask

  // Drives a read from ISSUE through DELIVER; returns what the arbiter presented.
  task automatic complete_read(input logic [W-1:0] data, output logic [N-1:0] vout,
                               output logic [W-1:0] vval, output logic [W-1:0] vaddr);
    lc_ready_in = 1'b1; tick(); lc_ready_in = 1'b0;
    lc_valid_in = 1'b1; lc_value_in = data; tick();
    lc_valid_in = 1'b0; lc_value_in = '0;
    #1;
    vout = hc_valid_out; vval = hc_value_out; vaddr = hc_addr_out;
    hc_ready_in = hc_valid_out; tick(); hc_ready_in = '0;
  endtask

  task automatic test_reset;
    clear_inputs();
    rst_N_in = 1'b0; hc_valid_in = '1; lc_valid_in = 1'b1;
    repeat (2) tick();
    #1;
    n_total++; if (hc_ready_out !== '0) $display("FAIL rst_hc_ready: got %b want 00", hc_ready_out); else n_pass++;
    n_total++; if ({busy_out, lc_valid_out, lc_ready_out, timeout_out} !== 4'b0) $display("FAIL rst_ctrl: got %b want 0000", {busy_out, lc_valid_out, lc_ready_out, timeout_out}); else n_pass++;
    n_total++; if ({hc_valid_out, hc_value_out, hc_addr_out} !== '0) $display("FAIL rst_hc_rsp: got %h want 0", {hc_valid_out, hc_value_out, hc_addr_out}); else n_pass++;
    n_total++; if ({lc_addr_out, lc_value_out, lc_we_out} !== '0) $display("FAIL rst_lc_req: got %h want 0", {lc_addr_out, lc_value_out, lc_we_out}); else n_pass++;
    clear_inputs(); rst_N_in = 1'b1; tick();
  endtask

  task automatic test_single_read;
    apply_reset();
    set_req(0, 64'h40, 64'h0, 1'b0); #1;
    n_total++; if (hc_ready_out !== 2'b01) $display("FAIL sr_grant: got %b want 01", hc_ready_out); else n_pass++;
    tick(); hc_valid_in = '0; #1;
    n_total++; if ({lc_valid_out, lc_we_out, busy_out} !== 3'b101) $display("FAIL sr_issue: got %b want 101", {lc_valid_out, lc_we_out, busy_out}); else n_pass++;
    n_total++; if (lc_addr_out !== 64'h40) $display("FAIL sr_lc_addr: got %h want 40", lc_addr_out); else n_pass++;
    tick(); #1;
    n_total++; if ({lc_valid_out, lc_addr_out} !== {1'b1, 64'h40}) $display("FAIL sr_hold: got %h want 1_40", {lc_valid_out, lc_addr_out}); else n_pass++;
    tick(); lc_ready_in = 1'b1; tick(); lc_ready_in = 1'b0; #1;
    n_total++; if ({lc_ready_out, lc_valid_out} !== 2'b10) $display("FAIL sr_wait: got %b want 10", {lc_ready_out, lc_valid_out}); else n_pass++;
    lc_valid_in = 1'b1; lc_value_in = 64'h0123456789ABCDEF; tick();
    lc_valid_in = 1'b0; lc_value_in = '1; #1;
    n_total++; if (hc_valid_out !== 2'b01) $display("FAIL sr_rsp_valid: got %b want 01", hc_valid_out); else n_pass++;
    n_total++; if (hc_value_out !== 64'h0123456789ABCDEF) $display("FAIL sr_rsp_value: got %h want 0123456789abcdef", hc_value_out); else n_pass++;
    n_total++; if (hc_addr_out !== 64'h40) $display("FAIL sr_rsp_addr: got %h want 40", hc_addr_out); else n_pass++;
    hc_ready_in = 2'b10; tick(); #1;
    n_total++; if ({hc_valid_out, hc_value_out} !== {2'b01, 64'h0123456789ABCDEF}) $display("FAIL sr_other_ready: got %h want 1_0123456789abcdef", {hc_valid_out, hc_value_out}); else n_pass++;
    hc_ready_in = 2'b01; tick(); hc_ready_in = '0; #1;
    n_total++; if ({busy_out, hc_valid_out} !== 3'b000) $display("FAIL sr_done: got %b want 000", {busy_out, hc_valid_out}); else n_pass++;
    n_total++; if ({hc_value_out, hc_addr_out} !== '0) $display("FAIL sr_rsp_zero: got %h want 0", {hc_value_out, hc_addr_out}); else n_pass++;
  endtask

  task automatic test_contention;
    logic [N-1:0] vo;
    logic [W-1:0] vv, va;
    apply_reset();
    set_req(0, 64'h0, 64'h0, 1'b0);
    set_req(1, 64'h4000, 64'h0, 1'b0); #1;
    n_total++; if (hc_ready_out !== 2'b01) $display("FAIL ct_grant0: got %b want 01", hc_ready_out); else n_pass++;
    tick(); hc_valid_in[0] = 1'b0; #1;
    n_total++; if ({lc_addr_out, hc_ready_out} !== {64'h0, 2'b00}) $display("FAIL ct_issue0: got %h want 0_0", {lc_addr_out, hc_ready_out}); else n_pass++;
    complete_read(64'hAAAA_0000_1111_2222, vo, vv, va);
    n_total++; if ({vo, vv} !== {2'b01, 64'hAAAA_0000_1111_2222}) $display("FAIL ct_rsp0: got %h want 1_aaaa000011112222", {vo, vv}); else n_pass++;
    #1;
    n_total++; if (hc_ready_out !== 2'b10) $display("FAIL ct_grant1: got %b want 10", hc_ready_out); else n_pass++;
    tick(); hc_valid_in[1] = 1'b0; #1;
    n_total++; if (lc_addr_out !== 64'h4000) $display("FAIL ct_issue1: got %h want 4000", lc_addr_out); else n_pass++;
    complete_read(64'hBBBB_3333_4444_5555, vo, vv, va);
    n_total++; if ({vo, vv, va} !== {2'b10, 64'hBBBB_3333_4444_5555, 64'h4000}) $display("FAIL ct_rsp1: got %h want 2_bbbb333344445555_4000", {vo, vv, va}); else n_pass++;
  endtask

  task automatic test_fairness;
    logic [N-1:0] vo, g, e;
    logic [W-1:0] vv, va;
    apply_reset();
    set_req(0, 64'h100, 64'h0, 1'b0);
    set_req(1, 64'h200, 64'h0, 1'b0);
    for (int t = 0; t < 6; t++) begin
      #1;
      g = hc_ready_out;
      e = '0; e[t % 2] = 1'b1;
      n_total++; if (g !== e) $display("FAIL fair_grant%0d: got %b want %b", t, g, e); else n_pass++;
      tick();
      complete_read({$urandom, $urandom}, vo, vv, va);
      n_total++; if (vo !== e) $display("FAIL fair_route%0d: got %b want %b", t, vo, e); else n_pass++;
    end
    clear_inputs();
  endtask

  task automatic test_write_backpressure;
    logic [N-1:0] vo;
    logic [W-1:0] vv, va;
    apply_reset();
    set_req(1, 64'h0, 64'hFEDCBA9876543210, 1'b1); #1;
    n_total++; if (hc_ready_out !== 2'b10) $display("FAIL wr_grant: got %b want 10", hc_ready_out); else n_pass++;
    tick(); clear_inputs();
    for (int c = 0; c < 5; c++) begin
      lc_valid_in = (c == 2);
      #1;
      n_total++; if ({lc_valid_out, lc_we_out, lc_addr_out, lc_value_out} !== {2'b11, 64'h0, 64'hFEDCBA9876543210})
        $display("FAIL wr_hold%0d: got %h want 3_0_fedcba9876543210", c, {lc_valid_out, lc_we_out, lc_addr_out, lc_value_out}); else n_pass++;
      tick();
    end
    lc_valid_in = 1'b0; lc_ready_in = 1'b1; #1;
    n_total++; if ({lc_valid_out, hc_valid_out} !== 3'b100) $display("FAIL wr_accept: got %b want 100", {lc_valid_out, hc_valid_out}); else n_pass++;
    tick(); lc_ready_in = 1'b0;
    set_req(0, 64'h200, 64'h0, 1'b0); #1;
    n_total++; if ({busy_out, lc_valid_out, lc_ready_out, hc_valid_out} !== 5'b0) $display("FAIL wr_idle: got %b want 00000", {busy_out, lc_valid_out, lc_ready_out, hc_valid_out}); else n_pass++;
    n_total++; if (hc_ready_out !== 2'b01) $display("FAIL wr_next_grant: got %b want 01", hc_ready_out); else n_pass++;
    tick(); hc_valid_in = '0;
    complete_read(64'h5A5A_5A5A_0F0F_0F0F, vo, vv, va);
    n_total++; if ({vo, vv, va} !== {2'b01, 64'h5A5A_5A5A_0F0F_0F0F, 64'h200}) $display("FAIL wr_then_read: got %h want 1_5a5a5a5a0f0f0f0f_200", {vo, vv, va}); else n_pass++;
  endtask

  task automatic test_timeout;
    apply_reset();
    set_req(0, 64'h80, 64'h0, 1'b0);
    tick(); hc_valid_in = '0;
    lc_ready_in = 1'b1; tick(); lc_ready_in = 1'b0;
    for (int j = 0; j < TO; j++) begin
      #1;
      n_total++; if ({timeout_out, lc_ready_out, busy_out} !== 3'b011) $display("FAIL to_wait%0d: got %b want 011", j, {timeout_out, lc_ready_out, busy_out}); else n_pass++;
      tick();
    end
    #1;
    n_total++; if ({timeout_out, busy_out, lc_ready_out} !== 3'b100) $display("FAIL to_pulse: got %b want 100", {timeout_out, busy_out, lc_ready_out}); else n_pass++;
    tick();
    lc_valid_in = 1'b1; lc_value_in = 64'hDEAD; #1;
    n_total++; if (timeout_out !== 1'b0) $display("FAIL to_one_cycle: got %b want 0", timeout_out); else n_pass++;
    tick(); lc_valid_in = 1'b0; #1;
    n_total++; if ({hc_valid_out, busy_out} !== 3'b000) $display("FAIL to_late_rsp: got %b want 000", {hc_valid_out, busy_out}); else n_pass++;
  endtask

  task automatic test_reset_mid;
    apply_reset();
    set_req(1, 64'h100, 64'h0, 1'b0);
    tick(); hc_valid_in = '0;
    lc_ready_in = 1'b1; tick(); lc_ready_in = 1'b0;
    lc_valid_in = 1'b1; lc_value_in = 64'h1234_5678_9ABC_DEF0; tick();
    lc_valid_in = 1'b0; #1;
    n_total++; if (hc_valid_out !== 2'b10) $display("FAIL rm_deliver: got %b want 10", hc_valid_out); else n_pass++;
    rst_N_in = 1'b0; #1;
    n_total++; if ({hc_valid_out, hc_value_out, hc_addr_out, busy_out} !== '0) $display("FAIL rm_outputs: got %h want 0", {hc_valid_out, hc_value_out, hc_addr_out, busy_out}); else n_pass++;
    n_total++; if ({lc_addr_out, lc_value_out, lc_we_out, lc_valid_out} !== '0) $display("FAIL rm_lc_outputs: got %h want 0", {lc_addr_out, lc_value_out, lc_we_out, lc_valid_out}); else n_pass++;
    tick(); hc_ready_in = '1; tick();
    rst_N_in = 1'b1; tick(); #1;
    n_total++; if ({hc_valid_out, busy_out} !== 3'b000) $display("FAIL rm_no_rsp: got %b want 000", {hc_valid_out, busy_out}); else n_pass++;
    hc_ready_in = '0;
    // Reset during ISSUE after serving requester 0: pointer must return to 0.
    set_req(0, 64'h300, 64'h0, 1'b0);
    tick(); hc_valid_in = '0; #1;
    n_total++; if (lc_valid_out !== 1'b1) $display("FAIL rm_issue: got %b want 1", lc_valid_out); else n_pass++;
    rst_N_in = 1'b0; #1;
    n_total++; if (lc_valid_out !== 1'b0) $display("FAIL rm_issue_drop: got %b want 0", lc_valid_out); else n_pass++;
    tick(); rst_N_in = 1'b1;
    set_req(0, 64'h400, 64'h0, 1'b0);
    set_req(1, 64'h500, 64'h0, 1'b0); #1;
    n_total++; if (hc_ready_out !== 2'b01) $display("FAIL rm_ptr_reset: got %b want 01", hc_ready_out); else n_pass++;
    tick(); clear_inputs();
  endtask

  // Transaction-level model: at most one open transaction; grants rotate from the
  // requester after the last one granted; reads return the cache data to their owner.
  task automatic test_random(input int ncyc);
    logic [N-1:0] pv, e_rdy, e_vld;
    logic [W-1:0] pa[N], pd[N];
    logic         pw[N];
    int           m_ptr, g, c_id, due;
    logic         open, sent, back, waiting, c_we;
    logic [W-1:0] c_addr, c_val, r_val;
    apply_reset();
    pv = '0; m_ptr = 0; open = 0; sent = 0; back = 0; due = 0;
    c_id = 0; c_we = 0; c_addr = '0; c_val = '0; r_val = '0;
    for (int i = 0; i < N; i++) begin pa[i] = '0; pd[i] = '0; pw[i] = 1'b0; end
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!pv[i] && $urandom_range(0, 3) == 0) begin
          pv[i] = 1'b1; pa[i] = {$urandom, $urandom}; pd[i] = {$urandom, $urandom};
          pw[i] = ($urandom_range(0, 2) == 0);
        end
        hc_addr_in[i*W +: W]  = pa[i];
        hc_value_in[i*W +: W] = pd[i];
        hc_we_in[i]          = pw[i];
      end
      hc_valid_in = pv;
      waiting     = open && sent && !back;
      lc_ready_in = ($urandom_range(0, 1) == 1);
      hc_ready_in = N'($urandom);
      lc_valid_in = waiting ? (due == 0) : ($urandom_range(0, 7) == 0);
      lc_value_in = (waiting && due == 0) ? r_val : {$urandom, $urandom};
      g = -1;
      if (!open)
        for (int k = 0; k < N; k++)
          if (g < 0 && pv[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      e_rdy = '0; if (g >= 0) e_rdy[g] = 1'b1;
      e_vld = '0; if (back) e_vld[c_id] = 1'b1;
      #1;
      n_total++; if (hc_ready_out !== e_rdy) $display("FAIL rnd_grant@%0d: got %b want %b", cyc, hc_ready_out, e_rdy); else n_pass++;
      n_total++; if (busy_out !== open) $display("FAIL rnd_busy@%0d: got %b want %b", cyc, busy_out, open); else n_pass++;
      n_total++; if (lc_valid_out !== (open && !sent)) $display("FAIL rnd_lc_valid@%0d: got %b want %b", cyc, lc_valid_out, open && !sent); else n_pass++;
      if (open && !sent) begin
        n_total++; if ({lc_addr_out, lc_value_out, lc_we_out} !== {c_addr, c_val, c_we})
          $display("FAIL rnd_lc_req@%0d: got %h want %h", cyc, {lc_addr_out, lc_value_out, lc_we_out}, {c_addr, c_val, c_we}); else n_pass++;
      end
      n_total++; if (lc_ready_out !== waiting) $display("FAIL rnd_lc_ready@%0d: got %b want %b", cyc, lc_ready_out, waiting); else n_pass++;
      n_total++; if (hc_valid_out !== e_vld) $display("FAIL rnd_hc_valid@%0d: got %b want %b", cyc, hc_valid_out, e_vld); else n_pass++;
      n_total++; if ({hc_value_out, hc_addr_out} !== (back ? {r_val, c_addr} : {2*W{1'b0}}))
        $display("FAIL rnd_hc_rsp@%0d: got %h want %h", cyc, {hc_value_out, hc_addr_out}, back ? {r_val, c_addr} : {2*W{1'b0}}); else n_pass++;
      n_total++; if (timeout_out !== 1'b0) $display("FAIL rnd_timeout@%0d: got %b want 0", cyc, timeout_out); else n_pass++;
      if (g >= 0) begin
        c_id = g; c_addr = pa[g]; c_val = pd[g]; c_we = pw[g];
        pv[g] = 1'b0; open = 1; sent = 0; back = 0; m_ptr = (g + 1) % N;
      end else if (open && !sent) begin
        if (lc_ready_in) begin
          if (c_we) open = 0;
          else begin sent = 1; due = $urandom_range(0, 5); r_val = {$urandom, $urandom}; end
        end
      end else if (waiting) begin
        if (lc_valid_in) back = 1; else due--;
      end else if (back && hc_ready_in[c_id]) begin
        open = 0; sent = 0; back = 0;
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rst_N_in = 1'b0;
    clear_inputs();
    test_reset();
    test_single_read();
    test_contention();
    test_fairness();
    test_write_backpressure();
    test_timeout();
    test_reset_mid();
    test_random(3000);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cache_port_arbiter.md
Name: cache_port_arbiter

Overview:
- Round-robin arbiter sharing the single higher-level request port of one blocking cache among NUM_REQ requesters (e.g. fetch unit and load/store unit).
- Accepts one request at a time, registers it, issues it to the cache and returns the read response to the originating requester.
- Write requests complete when the cache accepts them; they produce no response.
- Sits between the requesters and the cache's hc_* interface; its cache-facing side uses lc_* names.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- W, 64, address and data width.
- TIMEOUT, 1024, maximum cycles in WAIT_RSP before the transaction is abandoned.

Ports:
- clk_in  input  1  clock; all logic on posedge.
- rst_N_in  input  1  reset, asynchronous assert, active low.
- hc_valid_in  input  NUM_REQ  per-requester request valid.
- hc_ready_out  output  NUM_REQ  per-requester request accept.
- hc_addr_in  input  NUM_REQ*W  packed request addresses; requester i uses slice [i*W +: W].
- hc_value_in  input  NUM_REQ*W  packed write data.
- hc_we_in  input  NUM_REQ  per-requester write enable.
- hc_valid_out  output  NUM_REQ  response valid; one-hot or zero.
- hc_ready_in  input  NUM_REQ  per-requester response ready.
- hc_value_out  output  W  response data, shared by all requesters.
- hc_addr_out  output  W  address of the responded request.
- lc_valid_out  output  1  request valid to the cache (drives cache hc_valid_in).
- lc_ready_in  input  1  cache accepts the request (cache hc_ready_out).
- lc_addr_out  output  W  registered request address.
- lc_value_out  output  W  registered write data.
- lc_we_out  output  1  registered write enable.
- lc_valid_in  input  1  cache response valid (cache hc_valid_out).
- lc_ready_out  output  1  arbiter ready for the response (cache hc_ready_in).
- lc_value_in  input  W  cache response data.
- busy_out  output  1  high in any state other than IDLE.
- timeout_out  output  1  one-cycle pulse when a transaction is abandoned.

Behaviour:
- Reset (async, rst_N_in=0):
  - State = IDLE, rr_ptr = 0, timeout counter = 0.
  - All registered address, data and we fields = 0.
  - Every output = 0.
  - Reset asserted mid-transaction discards the transaction; no response is ever delivered for it.
- FSM states: IDLE, ISSUE, WAIT_RSP, DELIVER.
- IDLE:
  - Grant g is the first i with hc_valid_in[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - hc_ready_out[g]=1 combinationally; all other bits 0. No valid requests means no grant.
  - On the grant handshake: register addr, value, we and g; set rr_ptr = (g+1) mod NUM_REQ; go to ISSUE.
  - A requester is not granted twice in a row while another requester is valid.
- ISSUE:
  - lc_valid_out=1; lc_addr_out, lc_value_out and lc_we_out hold stable until lc_ready_in=1.
  - On lc_ready_in=1: if we=1, go to IDLE (write done); otherwise clear the counter and go to WAIT_RSP.
  - Earliest next grant after a write handshake is the following cycle.
- WAIT_RSP:
  - lc_ready_out=1.
  - On lc_valid_in=1: register lc_value_in and go to DELIVER.
  - Otherwise the counter increments. When it reaches TIMEOUT-1 without a response: pulse timeout_out for one cycle and go to IDLE.
  - lc_valid_in outside WAIT_RSP is ignored; lc_ready_out=0 in all other states.
- DELIVER:
  - hc_valid_out[g]=1, with hc_value_out and hc_addr_out registered and stable.
  - On hc_ready_in[g]=1, go to IDLE.
  - hc_ready_in of other requesters is ignored.
- Latency: grant handshake in cycle 0 gives lc_valid_out=1 in cycle 1. A cache response registered in cycle k gives hc_valid_out in cycle k+1.
- In IDLE, no hc_ready_out bit rises in the same cycle as a DELIVER handshake (the FSM is registered), so at most one transaction is in flight.
- hc_valid_out, hc_value_out and hc_addr_out are 0 outside DELIVER.

Test Plan:
- Single read: requester 0 reads addr 0x40; cache accepts after 2 cycles and responds 0x0123456789ABCDEF -> lc_addr_out=0x40, lc_we_out=0; hc_valid_out=2'b01 with value 0x0123456789ABCDEF one cycle after lc_valid_in; busy_out falls after the hc_ready_in handshake.
- Contention: both requesters valid in the same cycle with addrs 0x0 and 0x4000, rr_ptr=0 -> requester 0 is served first, then requester 1; lc_addr_out sequence 0x0 then 0x4000; responses routed to bits 0 then 1.
- Fairness: requesters 0 and 1 continuously valid for 6 transactions -> grant order 0,1,0,1,0,1.
- Write: requester 1 writes 0xFEDCBA9876543210 to 0x0 -> lc_we_out=1 and lc_value_out=0xFEDCBA9876543210 held until lc_ready_in; no hc_valid_out; back in IDLE the next cycle.
- Backpressure and timeout: with lc_ready_in=0 for 5 cycles, outputs stay stable. With TIMEOUT=16 and no lc_valid_in -> timeout_out pulses once, 16 cycles after entering WAIT_RSP, and state returns to IDLE.
- Reset mid-DELIVER: deassert rst_N_in while hc_valid_out=2'b10 -> all outputs 0 immediately; after release, rr_ptr=0 and the next grant goes to requester 0.
